// File: rtl/dac_delta_sigma.sv
// First-order delta-sigma DAC output stage: a one-entry sample buffer feeds a
// wrap-around accumulator that steps once every FREQ_DIV clocks.
module dac_delta_sigma #(
   parameter int BIT_WIDTH = 10,
   parameter int FREQ_DIV  = 5
) (
   input  logic                 CLK,
   input  logic                 RESET_n,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   input  logic [BIT_WIDTH-1:0] IN_DATA,
   output logic                 DAC_OUT,
   output logic                 SAMPLE_TICK
);
   localparam int               CNT_W    = (FREQ_DIV > 1) ? $clog2(FREQ_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FREQ_DIV - 1);

   logic [CNT_W-1:0]     r_div_cnt;
   logic                 r_buf_full;
   logic [BIT_WIDTH-1:0] r_buf;
   logic [BIT_WIDTH-1:0] r_cur;
   logic [BIT_WIDTH-1:0] r_acc;
   logic                 r_dac;
   logic                 r_sample_tick;

   logic                 w_tick;
   logic                 w_accept;
   logic [BIT_WIDTH-1:0] w_sel;
   logic [BIT_WIDTH-1:0] w_u;
   logic [BIT_WIDTH:0]   w_sum;

   assign w_tick   = (r_div_cnt == CNT_LAST);
   assign w_accept = IN_VALID && !r_buf_full;
   assign w_sel    = r_buf_full ? r_buf : r_cur;
   // flipping the sign bit turns two's complement into offset binary
   assign w_u      = {~w_sel[BIT_WIDTH-1], w_sel[BIT_WIDTH-2:0]};
   assign w_sum    = {1'b0, r_acc} + {1'b0, w_u};

   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         r_div_cnt     <= '0;
         r_buf_full    <= 1'b0;
         r_buf         <= '0;
         r_cur         <= '0;
         r_acc         <= '0;
         r_dac         <= 1'b0;
         r_sample_tick <= 1'b0;
      end else begin
         r_div_cnt     <= w_tick ? '0 : r_div_cnt + CNT_W'(1);
         r_sample_tick <= w_tick;
         if (w_tick) begin
            r_cur      <= w_sel;
            r_buf_full <= 1'b0;
            r_acc      <= w_sum[BIT_WIDTH-1:0];
            r_dac      <= w_sum[BIT_WIDTH];
         end
         // placed after the tick update so an accept on a tick edge keeps the buffer full
         if (w_accept) begin
            r_buf      <= IN_DATA;
            r_buf_full <= 1'b1;
         end
      end
   end

   assign IN_READY    = !r_buf_full;
   assign DAC_OUT     = r_dac;
   assign SAMPLE_TICK = r_sample_tick;

endmodule

// File: tb/tb_dac_delta_sigma.sv
// Bench for dac_delta_sigma: scoreboard of accepted samples checked at every
// modulator step, density vector table, and hand-written corner sequences.
module tb_dac_delta_sigma;
   localparam int W   = 10;
   localparam int DIV = 5;

   logic         CLK     = 1'b0;
   logic         RESET_n = 1'b0;
   logic         in_valid, in_ready, dac_out, sample_tick;
   logic [W-1:0] in_data;
   logic         in_valid1, in_ready1, dac_out1, sample_tick1;
   logic [W-1:0] in_data1;

   always #5 CLK = ~CLK;

   dac_delta_sigma #(.BIT_WIDTH(W), .FREQ_DIV(DIV)) dut (
      .CLK(CLK), .RESET_n(RESET_n), .IN_VALID(in_valid), .IN_READY(in_ready),
      .IN_DATA(in_data), .DAC_OUT(dac_out), .SAMPLE_TICK(sample_tick));

   dac_delta_sigma #(.BIT_WIDTH(W), .FREQ_DIV(1)) dut1 (
      .CLK(CLK), .RESET_n(RESET_n), .IN_VALID(in_valid1), .IN_READY(in_ready1),
      .IN_DATA(in_data1), .DAC_OUT(dac_out1), .SAMPLE_TICK(sample_tick1));

   typedef struct {logic [W-1:0] data; int edge_n;} sb_t;
   typedef struct {logic [W-1:0] sample; int ones;} vec_t;

   sb_t          sbq[$];
   vec_t         vecs[5];
   int           n_pass = 0;
   int           n_chk  = 0;
   int           ecnt   = 0;
   int           last_acc = -1;
   int           s_last = 0;
   logic [W-1:0] exp_cur = '0;
   logic [W-1:0] m_acc = '0;
   logic         exp_dac = 1'b0;
   logic         mon_tick;
   logic [W:0]   mon_sum;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
   endtask

   // edges since reset release
   always @(posedge CLK or negedge RESET_n)
      if (!RESET_n) ecnt <= 0;
      else          ecnt <= ecnt + 1;

   always @(posedge CLK)
      if (!RESET_n) last_acc <= -1;
      else if (in_valid && in_ready) begin
         sbq.push_back('{in_data, ecnt + 1});
         last_acc <= ecnt + 1;
      end

   always @(negedge CLK) begin
      if (!RESET_n) begin
         sbq.delete();
         exp_cur = '0; m_acc = '0; exp_dac = 1'b0; s_last = 0;
         chk("rst_dac", dac_out, 0);
         chk("rst_tick", sample_tick, 0);
         chk("rst_ready", in_ready, 1);
         chk("rst_ready1", in_ready1, 1);
      end else begin
         mon_tick = (ecnt > 0) && (ecnt % DIV == 0);
         chk("tick", sample_tick, mon_tick);
         if (mon_tick) begin
            s_last = ecnt;
            while (sbq.size() > 0 && sbq[0].edge_n < ecnt) begin
               exp_cur = sbq[0].data;
               void'(sbq.pop_front());
            end
            mon_sum = {1'b0, m_acc} + {1'b0, ~exp_cur[W-1], exp_cur[W-2:0]};
            m_acc   = mon_sum[W-1:0];
            exp_dac = mon_sum[W];
            chk("cur", dut.r_cur, exp_cur);
         end
         chk("dac", dac_out, exp_dac);
         chk("ready", in_ready, !(last_acc >= s_last && last_acc > 0));
      end
   end

   task automatic idle_pattern(input string name);
      int seen = 0;
      int guard = 0;
      while (seen < 4 && guard < 100) begin
         @(negedge CLK);
         guard++;
         if (sample_tick) begin
            chk({name, "_dac"}, dac_out, seen % 2);
            chk({name, "_edge"}, ecnt, DIV * (seen + 1));
            seen++;
         end
      end
      if (seen < 4) chk({name, "_timeout"}, seen, 4);
   endtask

   task automatic send(input logic [W-1:0] d);
      int guard = 0;
      @(negedge CLK);
      while (!in_ready && guard < 50) begin
         @(negedge CLK);
         guard++;
      end
      if (!in_ready) chk("send_timeout", in_ready, 1);
      in_valid = 1'b1;
      in_data  = d;
      @(negedge CLK);
      in_valid = 1'b0;
   endtask

   task automatic density(input string name, input int req_ones);
      int steps = 0;
      int ones = 0;
      int guard = 0;
      while (steps < 1024 && guard < 1024 * DIV + 20) begin
         @(negedge CLK);
         guard++;
         if (sample_tick) begin
            steps++;
            ones += int'(dac_out);
         end
      end
      chk({name, "_steps"}, steps, 1024);
      chk(name, ones, req_ones);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected finish before 1000000");
      $fatal(1);
   end

   initial begin
      int           prev;
      int           n_acc;
      int           g;
      int           steps1;
      int           ones1;
      logic         r;
      logic [W-1:0] last_hs;

      in_valid = 0; in_data = '0; in_valid1 = 0; in_data1 = '0;
      vecs[0] = '{10'h1FF, 1023};
      vecs[1] = '{10'h200, 0};
      vecs[2] = '{10'h100, 768};
      vecs[3] = '{10'h300, 256};
      vecs[4] = '{10'h000, 512};

      repeat (2) @(posedge CLK);
      #2;
      chk("init_dac", dac_out, 0);
      chk("init_tick", sample_tick, 0);
      chk("init_ready", in_ready, 1);
      RESET_n = 1'b1;
      idle_pattern("idle");

      for (int i = 0; i < 5; i++) begin
         send(vecs[i].sample);
         density($sformatf("dens_%03h", vecs[i].sample), vecs[i].ones);
      end

      // sustained input: valid held high, data advances on every accept
      in_data = 10'h010;
      in_valid = 1'b1;
      prev = -1; n_acc = 0; last_hs = '0;
      @(negedge CLK);
      for (int c = 0; c < 60; c++) begin
         r = in_ready;
         @(negedge CLK);
         if (r) begin
            if (prev >= 0) chk("hs_gap", ecnt - prev, DIV);
            prev = ecnt;
            n_acc++;
            last_hs = in_data;
            in_data = in_data + 1'b1;
         end
      end
      in_valid = 1'b0;
      chk("hs_count", n_acc, 12);

      // accept on the edge of a tick with the buffer empty
      repeat (3 * DIV) @(negedge CLK);
      g = 0;
      while (ecnt % DIV != DIV - 1 && g < 20) begin
         @(negedge CLK);
         g++;
      end
      chk("sim_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = 10'h155;
      @(negedge CLK);
      in_valid = 1'b0;
      chk("sim_cur_old", dut.r_cur, last_hs);
      chk("sim_full", in_ready, 0);
      repeat (DIV - 1) @(negedge CLK);
      chk("sim_cur_wait", dut.r_cur, last_hs);
      @(negedge CLK);
      chk("sim_cur_new", dut.r_cur, 10'h155);
      chk("sim_ready_back", in_ready, 1);

      // mid-operation reset with a sample sitting in the buffer
      g = 0;
      @(negedge CLK);
      while (ecnt % DIV != 0 && g < 20) begin
         @(negedge CLK);
         g++;
      end
      in_valid = 1'b1;
      in_data  = 10'h0A5;
      @(negedge CLK);
      in_valid = 1'b0;
      chk("pre_full", in_ready, 0);
      chk("pre_acc", dut.r_acc, m_acc);
      @(posedge CLK);
      #2 RESET_n = 1'b0;
      #1;
      chk("mid_rst_dac", dac_out, 0);
      chk("mid_rst_tick", sample_tick, 0);
      chk("mid_rst_ready", in_ready, 1);
      chk("mid_rst_acc", dut.r_acc, 0);
      chk("mid_rst_cur", dut.r_cur, 0);
      repeat (2) @(posedge CLK);
      #2 RESET_n = 1'b1;
      idle_pattern("post_rst");

      // FREQ_DIV=1 instance: one step per clock, same density
      @(negedge CLK);
      in_valid1 = 1'b1;
      in_data1  = 10'h100;
      @(negedge CLK);
      in_valid1 = 1'b0;
      chk("div1_ready_low", in_ready1, 0);
      steps1 = 0; ones1 = 0;
      for (int c = 0; c < 1024; c++) begin
         @(negedge CLK);
         steps1 += int'(sample_tick1);
         ones1  += int'(dac_out1);
      end
      chk("div1_steps", steps1, 1024);
      chk("div1_ones", ones1, 768);
      chk("div1_ready_back", in_ready1, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
